// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter.
// Shifts a latched PAT_W-bit pattern out MSB-first, once per frame, for a programmable
// number of frames. An optional run of idle cycles separates consecutive frames.
// Every output except start_ready is a flop, computed from the next-state values.
module seq_pattern_tx #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             bit_o,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int unsigned    IdxW   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IdxW-1:0] IdxMsb = IdxW'(PAT_W - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StGap   = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;
   logic [PAT_W-1:0] pat_q, pat_d;

   logic bit_o_q, bit_o_d;
   logic bit_valid_q, bit_valid_d;
   logic frame_start_q, frame_start_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic accept;

   // Abort blocks a start in the same cycle, so it is folded into ready.
   assign start_ready = (state_q == StIdle) & ~abort & ~rst;
   assign accept      = start_valid & start_ready;

   // Next-state: handshake capture, bit/frame/gap counting, abort back to idle
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      pat_d   = pat_q;
      if ((state_q != StIdle) && abort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  pat_d   = pattern;
                  gap_d   = gap;
                  rem_d   = repeat_cnt;
                  idx_d   = IdxMsb;
                  state_d = (repeat_cnt == '0) ? StDone : StShift;
               end
            end
            StShift: begin
               if (idx_q == '0) begin
                  rem_d = rem_q - CNT_W'(1);
                  idx_d = IdxMsb;
                  if (rem_q <= CNT_W'(1)) begin
                     state_d = StDone;
                  end else if (gap_q != '0) begin
                     state_d = StGap;
                     gcnt_d  = gap_q;
                  end
                  // gap of zero: stay in SHIFT and send the next MSB without a bubble
               end else begin
                  idx_d = idx_q - IdxW'(1);
               end
            end
            StGap: begin
               if (gcnt_q <= GAP_W'(1)) begin
                  state_d = StShift;
                  idx_d   = IdxMsb;
                  gcnt_d  = '0;
               end else begin
                  gcnt_d = gcnt_q - GAP_W'(1);
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Registered outputs reflect the state being entered, so the MSB appears right after accept
   always_comb begin
      bit_valid_d   = (state_d == StShift);
      bit_o_d       = bit_valid_d & pat_d[idx_d];
      frame_start_d = bit_valid_d & (idx_d == IdxMsb);
      busy_d        = (state_d != StIdle);
      done_d        = (state_d == StDone);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         rem_q         <= '0;
         gap_q         <= '0;
         gcnt_q        <= '0;
         pat_q         <= '0;
         bit_o_q       <= 1'b0;
         bit_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         rem_q         <= rem_d;
         gap_q         <= gap_d;
         gcnt_q        <= gcnt_d;
         pat_q         <= pat_d;
         bit_o_q       <= bit_o_d;
         bit_valid_q   <= bit_valid_d;
         frame_start_q <= frame_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bit_o       = bit_o_q;
   assign bit_valid   = bit_valid_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a timeline model predicts every output cycle by cycle from
// the accept cycle, pattern, repeat count and gap; directed scenarios add literal checks.
module tb_seq_pattern_tx;

   localparam int PAT_W = 4;
   localparam int CNT_W = 8;
   localparam int GAP_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_valid;
   logic             start_ready;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] repeat_cnt;
   logic [GAP_W-1:0] gap;
   logic             abort;
   logic             bit_o;
   logic             bit_valid;
   logic             frame_start;
   logic             busy;
   logic             done;

   seq_pattern_tx #(
      .PAT_W(PAT_W),
      .CNT_W(CNT_W),
      .GAP_W(GAP_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .pattern    (pattern),
      .repeat_cnt (repeat_cnt),
      .gap        (gap),
      .abort      (abort),
      .bit_o      (bit_o),
      .bit_valid  (bit_valid),
      .frame_start(frame_start),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h cycle=%0d", name, got, want, cyc);
      end
   endtask

   // Model: one transaction is live from the cycle after accept through its done cycle
   bit               m_active = 1'b0;
   int               m_t0     = 0;
   logic [PAT_W-1:0] m_pat    = '0;
   int               m_r      = 0;
   int               m_g      = 0;

   function automatic int span_of(input int r, input int g);
      return (r == 0) ? 0 : r * PAT_W + (r - 1) * g;
   endfunction

   // Model update at each edge; cycle c is the interval ending at the edge where cyc==c
   always @(posedge clk) begin
      if (rst) begin
         m_active <= 1'b0;
      end else if (m_active) begin
         if (abort || (cyc == m_t0 + span_of(m_r, m_g) + 1)) m_active <= 1'b0;
      end else if (start_valid && !abort) begin
         m_active <= 1'b1;
         m_t0     <= cyc;
         m_pat    <= pattern;
         m_r      <= int'(repeat_cnt);
         m_g      <= int'(gap);
      end
      cyc <= cyc + 1;
   end

   // Recorders for the directed literal checks
   logic [63:0] cap;
   int          ncap;
   logic [63:0] fs_mask;
   int          done_rel;
   int          done_seen;
   int          ready_rel;
   int          t_acc = 0;

   // Compare process: every cycle, mid-period, DUT outputs against the model timeline
   always @(negedge clk) begin : cmp
      int k, sp, pos;
      logic ev, eb, efs, ebusy, edone, erdy;
      ev = 1'b0; eb = 1'b0; efs = 1'b0; ebusy = 1'b0; edone = 1'b0;
      if (m_active) begin
         k  = cyc - m_t0 - 1;
         sp = span_of(m_r, m_g);
         ebusy = 1'b1;
         if (k < sp) begin
            pos = k % (PAT_W + m_g);
            if (pos < PAT_W) begin
               ev  = 1'b1;
               eb  = m_pat[PAT_W-1-pos];
               efs = (pos == 0);
            end
         end else begin
            edone = 1'b1;
         end
      end
      erdy = !m_active && !abort && !rst;
      chk("bit_valid", 64'(bit_valid), 64'(ev));
      chk("bit_o", 64'(bit_o), 64'(eb));
      chk("frame_start", 64'(frame_start), 64'(efs));
      chk("busy", 64'(busy), 64'(ebusy));
      chk("done", 64'(done), 64'(edone));
      chk("start_ready", 64'(start_ready), 64'(erdy));
      if (bit_valid === 1'b1) begin
         cap  = {cap[62:0], bit_o};
         ncap = ncap + 1;
      end
      if (frame_start === 1'b1 && (cyc - t_acc) < 64) fs_mask[cyc - t_acc] = 1'b1;
      if (done === 1'b1) begin
         done_rel  = cyc - t_acc;
         done_seen = done_seen + 1;
      end
      if (start_ready === 1'b1 && ready_rel < 0 && cyc > t_acc) ready_rel = cyc - t_acc;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_rec();
      cap = '0; ncap = 0; fs_mask = '0; done_rel = -1; done_seen = 0; ready_rel = -1;
   endtask

   // Presents a start in the current cycle; the DUT must be idle here
   task automatic start_tx(input logic [PAT_W-1:0] p, input int r, input int g);
      pattern     = p;
      repeat_cnt  = CNT_W'(r);
      gap         = GAP_W'(g);
      start_valid = 1'b1;
      t_acc       = cyc;
      clear_rec();
      step();
      start_valid = 1'b0;
   endtask

   initial begin
      clear_rec();
      rst = 1'b1; start_valid = 1'b1; abort = 1'b0;
      pattern = 4'b1011; repeat_cnt = 8'd1; gap = 4'd0;
      step();
      chk("rst_ready", 64'(start_ready), 64'd0);
      step();
      step();
      rst = 1'b0; start_valid = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_no_accept", 64'(ncap), 64'd0);

      // Single frame 1011
      start_tx(4'b1011, 1, 0);
      repeat (7) step();
      chk("r1_bits", cap, 64'b1011);
      chk("r1_nbits", 64'(ncap), 64'd4);
      chk("r1_fs", fs_mask, 64'h2);
      chk("r1_done", 64'(done_rel), 64'd5);

      // Three frames, no gap
      start_tx(4'b1011, 3, 0);
      repeat (15) step();
      chk("r3_bits", cap, 64'hBBB);
      chk("r3_nbits", 64'(ncap), 64'd12);
      chk("r3_fs", fs_mask, 64'h222);
      chk("r3_done", 64'(done_rel), 64'd13);

      // Two frames, two idle cycles between
      start_tx(4'b1011, 2, 2);
      repeat (13) step();
      chk("r2g2_bits", cap, 64'hBB);
      chk("r2g2_nbits", 64'(ncap), 64'd8);
      chk("r2g2_fs", fs_mask, 64'h82);
      chk("r2g2_done", 64'(done_rel), 64'd11);

      // Zero repeats: done only
      start_tx(4'b1011, 0, 5);
      repeat (3) step();
      chk("r0_nbits", 64'(ncap), 64'd0);
      chk("r0_done", 64'(done_rel), 64'd1);
      chk("r0_ready", 64'(ready_rel), 64'd2);

      // Abort in cycle 2 of a frame, restart in cycle 3, stray starts while busy
      start_tx(4'b1011, 1, 0);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_nbits", 64'(ncap), 64'd2);
      chk("abort_bits", cap, 64'b10);
      chk("abort_no_done", 64'(done_seen), 64'd0);
      start_tx(4'b0110, 1, 0);
      pattern = 4'b1111; repeat_cnt = 8'd5; start_valid = 1'b1;
      step();
      step();
      start_valid = 1'b0;
      repeat (6) step();
      chk("restart_bits", cap, 64'b0110);
      chk("restart_nbits", 64'(ncap), 64'd4);
      chk("restart_done", 64'(done_rel), 64'd5);

      // Reset during the gap of R=2, G=3
      start_tx(4'b1011, 2, 3);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (12) step();
      chk("rstgap_nbits", 64'(ncap), 64'd4);
      chk("rstgap_no_done", 64'(done_seen), 64'd0);

      // Abort beats start in idle
      clear_rec();
      abort = 1'b1; start_valid = 1'b1; pattern = 4'b1001; repeat_cnt = 8'd1;
      step();
      abort = 1'b0; start_valid = 1'b0;
      repeat (6) step();
      chk("idle_abort_nbits", 64'(ncap), 64'd0);
      chk("idle_abort_no_done", 64'(done_seen), 64'd0);

      // Resumes normally afterwards
      start_tx(4'b1001, 1, 0);
      repeat (7) step();
      chk("final_bits", cap, 64'b1001);
      chk("final_done", 64'(done_rel), 64'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
